// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the 16-bit datapath.
//
// Merges the pipeline MEM/WB result with multiply/divide results and drives
// the two register-file write ports (general destination port + R15 port).
// Multiply/divide results wait in a DEPTH-entry FIFO and drain only in slots
// where the pipeline is not writing back; the pipeline always wins.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   pl_valid/pl_dst/pl_data     pipeline writeback (no backpressure)
//   md_valid/md_ready           mul/div result handshake (ready = FIFO not full)
//   md_dst/md_lo/md_hi          mul/div destination, low half / quotient, high half / remainder
//   wr/regDst/regDstData        registered destination write port
//   wrR15/regR15Data            registered R15 write port
//   pend_mask                   pending-write scoreboard (only with WB_SCOREBOARD_EN)
//
// Optional feature macro: WB_SCOREBOARD_EN adds the pend_mask output.
//
// state | meaning
// IDLE  | no half-issued FIFO entry; may issue pipeline or FIFO head
// SPLIT | head (dst 0 or 15) had its lo half written; hi -> R15 still owed

module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pl_valid,
    input  logic [3:0]  pl_dst,
    input  logic [15:0] pl_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [3:0]  md_dst,
    input  logic [15:0] md_lo,
    input  logic [15:0] md_hi,
    output logic        wr,
    output logic [3:0]  regDst,
    output logic [15:0] regDstData,
    output logic        wrR15,
    output logic [15:0] regR15Data
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [15:0] pend_mask
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t          state, stateNext;
    logic [3:0]      fDst [DEPTH];
    logic [15:0]     fLo  [DEPTH];
    logic [15:0]     fHi  [DEPTH];
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   count;
    logic            push, pop, empty;
    logic [3:0]      headDst;
    logic [15:0]     headLo, headHi;

    logic            wrNext, wrR15Next;
    logic [3:0]      regDstNext;
    logic [15:0]     regDstDataNext, regR15DataNext;

    assign md_ready = (count < DEPTH_C);
    assign empty    = (count == '0);
    assign push     = md_valid && md_ready;
    assign headDst  = fDst[rdPtr];
    assign headLo   = fLo[rdPtr];
    assign headHi   = fHi[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fDst[wrPtr] <= md_dst;
            fLo[wrPtr]  <= md_lo;
            fHi[wrPtr]  <= md_hi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr         <= 1'b0;
            regDst     <= '0;
            regDstData <= '0;
            wrR15      <= 1'b0;
            regR15Data <= '0;
        end else begin
            state      <= stateNext;
            wr         <= wrNext;
            regDst     <= regDstNext;
            regDstData <= regDstDataNext;
            wrR15      <= wrR15Next;
            regR15Data <= regR15DataNext;
        end
    end

    always_comb begin
        stateNext      = state;
        wrNext         = 1'b0;
        wrR15Next      = 1'b0;
        regDstNext     = regDst;
        regDstDataNext = regDstData;
        regR15DataNext = regR15Data;
        pop            = 1'b0;
        if (pl_valid) begin
            wrNext         = 1'b1;
            regDstNext     = pl_dst;
            regDstDataNext = pl_data;
        end else if (state == SPLIT) begin
            wrR15Next      = 1'b1;
            regR15DataNext = headHi;
            pop            = 1'b1;
            stateNext      = IDLE;
        end else if (!empty) begin
            wrNext         = 1'b1;
            regDstNext     = headDst;
            regDstDataNext = headLo;
            // Dual write is unsafe for R0 (R15 write dropped) and R15 (double write),
            // so defer the hi half to the next free slot.
            if (headDst == 4'd0 || headDst == 4'd15) begin
                stateNext = SPLIT;
            end else begin
                wrR15Next      = 1'b1;
                regR15DataNext = headHi;
                pop            = 1'b1;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    // Covers every write from FIFO entry until the register file commits it.
    always_comb begin
        pend_mask = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) < count) pend_mask[fDst[rdPtr + PW'(j)]] = 1'b1;
        end
        if (!empty) pend_mask[15] = 1'b1;
        if (wr)     pend_mask[regDst] = 1'b1;
        if (wrR15)  pend_mask[15] = 1'b1;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and a decoupled output monitor.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pl_valid = 1'b0;
    logic [3:0]  pl_dst = '0;
    logic [15:0] pl_data = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [3:0]  md_dst = '0;
    logic [15:0] md_lo = '0;
    logic [15:0] md_hi = '0;
    logic        wr;
    logic [3:0]  regDst;
    logic [15:0] regDstData;
    logic        wrR15;
    logic [15:0] regR15Data;
`ifdef WB_SCOREBOARD_EN
    logic [15:0] pend_mask;
`endif

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pl_valid(pl_valid), .pl_dst(pl_dst), .pl_data(pl_data),
        .md_valid(md_valid), .md_ready(md_ready),
        .md_dst(md_dst), .md_lo(md_lo), .md_hi(md_hi),
        .wr(wr), .regDst(regDst), .regDstData(regDstData),
        .wrR15(wrR15), .regR15Data(regR15Data)
`ifdef WB_SCOREBOARD_EN
        , .pend_mask(pend_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [3:0]  d;
        logic [15:0] dd;
        bit          w15;
        logic [15:0] hd;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] lo;
        logic [15:0] hi;
    } md_t;

    ev_t  expQ[$];
    md_t  mq[$];
    bit   loDone;         // head of mq already had its lo half written
    bit   lastW, lastW15; // what the model says the registered outputs hold
    logic [3:0] lastD;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] modelMask();
        logic [15:0] m = '0;
        foreach (mq[i]) m[mq[i].dst] = 1'b1;
        if (mq.size() != 0) m[15] = 1'b1;
        if (lastW)   m[lastD] = 1'b1;
        if (lastW15) m[15] = 1'b1;
        return m;
    endfunction

    // Monitor: every presented write must match the next expected one, at the expected cycle.
    always @(posedge clk) begin
        #1;
        if (rst && (wr || wrR15)) begin
            if (expQ.size() == 0) begin
                chk("unexpected_write", {wr, wrR15, regDst, regDstData}, 32'h0);
            end else begin
                ev_t e;
                e = expQ.pop_front();
                chk("issue_cycle", cyc, e.cyc);
                chk("wr", wr, e.w);
                chk("wrR15", wrR15, e.w15);
                if (e.w) begin
                    chk("regDst", regDst, e.d);
                    chk("regDstData", regDstData, e.dd);
                end
                if (e.w15) chk("regR15Data", regR15Data, e.hd);
            end
        end
    end

    task automatic step(input bit plv, input logic [3:0] pd, input logic [15:0] pdat,
                        input bit mdv, input logic [3:0] mdd, input logic [15:0] lo,
                        input logic [15:0] hi);
        ev_t e;
        bit  acc;
        @(negedge clk);
        chk("md_ready", md_ready, (mq.size() < DEPTH));
`ifdef WB_SCOREBOARD_EN
        chk("pend_mask", pend_mask, modelMask());
`endif
        pl_valid = plv; pl_dst = pd; pl_data = pdat;
        md_valid = mdv; md_dst = mdd; md_lo = lo; md_hi = hi;
        acc = mdv && (mq.size() < DEPTH);
        e = '{w: 1'b0, d: 4'd0, dd: 16'd0, w15: 1'b0, hd: 16'd0, cyc: cyc + 1};
        if (plv) begin
            e.w = 1'b1; e.d = pd; e.dd = pdat;
        end else if (mq.size() != 0) begin
            if (loDone) begin
                e.w15 = 1'b1; e.hd = mq[0].hi;
                void'(mq.pop_front());
                loDone = 1'b0;
            end else if (mq[0].dst == 4'd0 || mq[0].dst == 4'd15) begin
                e.w = 1'b1; e.d = mq[0].dst; e.dd = mq[0].lo;
                loDone = 1'b1;
            end else begin
                e.w = 1'b1; e.d = mq[0].dst; e.dd = mq[0].lo;
                e.w15 = 1'b1; e.hd = mq[0].hi;
                void'(mq.pop_front());
            end
        end
        if (e.w || e.w15) expQ.push_back(e);
        lastW = e.w; lastW15 = e.w15;
        if (e.w) lastD = e.d;
        if (acc) mq.push_back('{dst: mdd, lo: lo, hi: hi});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkReset();
        chk("rst_wr", wr, 0);
        chk("rst_wrR15", wrR15, 0);
        chk("rst_regDst", regDst, 0);
        chk("rst_regDstData", regDstData, 0);
        chk("rst_regR15Data", regR15Data, 0);
        chk("rst_md_ready", md_ready, 1);
`ifdef WB_SCOREBOARD_EN
        chk("rst_pend_mask", pend_mask, 0);
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        pl_valid = 1'b0; md_valid = 1'b0;
        mq.delete(); loDone = 0; lastW = 0; lastW15 = 0;
        #1;
        checkReset();
        @(negedge clk);
        checkReset();
        rst = 1'b1;
    endtask

    initial begin
        loDone = 0; lastW = 0; lastW15 = 0; lastD = 0;
        #1;
        checkReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // single push, dual write
        step(0, 0, 0, 1, 4'd3, 16'h1234, 16'h00AB);
        idle(3);
        // split on R0
        step(0, 0, 0, 1, 4'd0, 16'hAAAA, 16'h5555);
        idle(3);
        // pipeline priority with FIFO filling up
        step(1, 4'd5, 16'h0040, 1, 4'd1, 16'h0101, 16'h0202);
        step(1, 4'd5, 16'h0040, 1, 4'd2, 16'h0303, 16'h0404);
        step(1, 4'd5, 16'h0040, 1, 4'd4, 16'h0505, 16'h0606);
        step(1, 4'd5, 16'h0040, 0, 0, 0, 0);
        idle(5);
        // split preempted by pipeline
        step(0, 0, 0, 1, 4'd15, 16'h1515, 16'h5151);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 4'd2, 16'h7777, 0, 0, 0, 0);
        idle(3);
        // scoreboard window for dst=7
        step(0, 0, 0, 1, 4'd7, 16'h0777, 16'h7000);
        idle(3);
        // reset while in SPLIT
        step(0, 0, 0, 1, 4'd0, 16'h1111, 16'h2222);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        doReset();
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit plv, mdv;
            logic [3:0] d;
            plv = ($urandom_range(0, 9) < 4);
            mdv = ($urandom_range(0, 9) < 5);
            d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15)
                                            : 4'($urandom);
            step(plv, 4'($urandom), 16'($urandom), mdv, d, 16'($urandom), 16'($urandom));
        end
        idle(3 * DEPTH + 4);
        @(negedge clk);
        chk("expected_queue_drained", expQ.size(), 0);
        chk("model_fifo_drained", mq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
